seq_logic_unit: RTL and testbench
=================================

SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter SLICE, default 16, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, else elaboration SHALL fail; NSLICE = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and op presented.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 op  input  2  00 AND, 01 OR, 10 XOR, 11 ANDN (input1 & ~input2).
REQ-008 input1  input  WIDTH  first operand.
REQ-009 input2  input  WIDTH  second operand.
REQ-010 out  output  WIDTH  result.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 zero  output  1  result is all zeros.
REQ-014 ones  output  1  result is all ones.

Function
REQ-015 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = in_valid & in_ready; on accept, input1, input2 and op SHALL be latched, result register cleared, slice counter set to 0, and next state SHALL be RUN.
REQ-017 In IDLE without accept, state SHALL remain IDLE.
REQ-018 Each RUN cycle SHALL compute slice [cnt*SLICE +: SLICE] of the latched operands with the latched op and write it into the result register, then increment cnt.
REQ-019 When cnt = NSLICE-1 in RUN, the final slice SHALL be written and next state SHALL be DONE.
REQ-020 Latency: accept at edge k -> out_valid = 1 after edge k+NSLICE (4 cycles at defaults, 1 cycle when SLICE = WIDTH).
REQ-021 In DONE, out_valid = 1; out, zero and ones SHALL hold stable until out_ready = 1.
REQ-022 DONE with out_ready = 1 -> IDLE at the next edge; no new request is accepted in that same cycle.
REQ-023 Outside DONE: out = 0, out_valid = 0, zero = 0, ones = 0.
REQ-024 zero = (result == 0) and ones = (result == all ones), both qualified by DONE.
REQ-025 Changes on input1, input2, op or in_valid during RUN/DONE SHALL have no effect.
REQ-026 out_ready outside DONE SHALL be ignored.
REQ-027 Result bits are pure bitwise functions; no carries, no width growth; bit i depends only on bit i of each operand.

Reset
REQ-028 rst = 1 at an edge SHALL force IDLE, cnt = 0, result = 0, latched operands = 0, latched op = 00, regardless of state.
REQ-029 After reset: in_ready = 1, out_valid = 0, out = 0, zero = 0, ones = 0.
REQ-030 Reset during RUN or DONE SHALL abandon the request without producing out_valid; reset takes priority over accept and out_ready in the same cycle.

Verification
REQ-031 Defaults, op=00, input1=64'hFFFF_0000_F0F0_1234, input2=64'h0F0F_FFFF_FF00_00FF -> out_valid after exactly 4 edges, out=64'h0F0F_0000_F000_0034, zero=0, ones=0.
REQ-032 op=10, input1=input2=64'hDEAD_BEEF_CAFE_F00D -> out=0, zero=1; then op=01, input1=64'hAAAA_AAAA_AAAA_AAAA, input2=64'h5555_5555_5555_5555 -> out=all ones, ones=1.
REQ-033 op=11, input1=64'hFFFF_FFFF_FFFF_FFFF, input2=64'h0000_0000_0000_00FF, out_ready held 0 for 10 cycles -> out=64'hFFFF_FFFF_FFFF_FF00 stable throughout, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Accept, then change input1/input2/op every RUN cycle and pulse in_valid -> result matches the originally latched values; exactly one out_valid episode.
REQ-035 Assert rst during 2nd RUN cycle -> next edge in_ready=1, out_valid=0, out=0; no out_valid appears later without a new accept.
REQ-036 Re-elaborate WIDTH=32, SLICE=32 and WIDTH=24, SLICE=8 with random operands, all four ops, 1000 requests, random out_ready stalls -> latency 1 and 3 cycles respectively; every out equals the bitwise reference model.

Source files
------------

// File: rtl/seq_logic_unit.sv
// rtl/seq_logic_unit.sv - multi-cycle sliced bitwise logic unit (AND/OR/XOR/ANDN)
//
// Purpose: accepts two WIDTH-bit operands and an op code and builds the bitwise
// result SLICE bits per cycle. The result is presented until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request present (op, input1, input2)
//   in_ready   unit idle and able to accept a request
//   op         00 AND, 01 OR, 10 XOR, 11 ANDN (input1 & ~input2)
//   input1     first operand
//   input2     second operand
//   out        result (zero outside DONE)
//   out_valid  result available
//   out_ready  consumer takes the result
//   zero       result is all zeros (DONE only)
//   ones       result is all ones (DONE only)

module seq_logic_unit #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             ones
);

    localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("seq_logic_unit: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_r;

    // Current slice of the latched operands; only meaningful in RUN.
    always_comb begin
        slice_a = a_q[int'(cnt_q) * SLICE +: SLICE];
        slice_b = b_q[int'(cnt_q) * SLICE +: SLICE];
        case (op_q)
            OP_AND:  slice_r = slice_a & slice_b;
            OP_OR:   slice_r = slice_a | slice_b;
            OP_XOR:  slice_r = slice_a ^ slice_b;
            default: slice_r = slice_a & ~slice_b;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                // in_ready is high only here, so in_valid alone means accept.
                if (in_valid) begin
                    a_d     = input1;
                    b_d     = input2;
                    op_d    = op;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[int'(cnt_q) * SLICE +: SLICE] = slice_r;
                if (cnt_q == CW'(NSLICE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    // Outputs are forced low outside DONE so a partial result never leaks.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        out       = out_valid ? res_q : '0;
        zero      = out_valid & (res_q == '0);
        ones      = out_valid & (&res_q);
    end

endmodule

// File: tb/tb_seq_logic_unit.sv
// tb/tb_seq_logic_unit.sv - directed self-checking bench for seq_logic_unit

module tb_seq_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        zero;
    logic        ones;

    logic        s_in_valid;
    logic [1:0]  s_op;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_out_ready;
    logic        a_in_ready, a_out_valid, a_zero, a_ones;
    logic [31:0] a_out;
    logic        b_in_ready, b_out_valid, b_zero, b_ones;
    logic [23:0] b_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_logic_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .input1(in1), .input2(in2), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .zero(zero), .ones(ones)
    );

    seq_logic_unit #(.WIDTH(32), .SLICE(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(a_in_ready), .op(s_op),
        .input1(s_a), .input2(s_b), .out(a_out), .out_valid(a_out_valid),
        .out_ready(s_out_ready), .zero(a_zero), .ones(a_ones)
    );

    seq_logic_unit #(.WIDTH(24), .SLICE(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(b_in_ready), .op(s_op),
        .input1(s_a[23:0]), .input2(s_b[23:0]), .out(b_out), .out_valid(b_out_valid),
        .out_ready(s_out_ready), .zero(b_zero), .ones(b_ones)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] a,
                                           input logic [63:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns one step after the accepting edge.
    task automatic start(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          extra;
        logic        stable;
        logic [63:0] snap;
        logic [63:0] e;
        int          la, lb;
        logic [31:0] oa;
        logic [23:0] ob;
        logic        obz, obo;

        rst = 1'b1; in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0; s_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ones", 64'(ones), 64'd0);

        // AND, four-slice latency
        start(2'b00, 64'hFFFF_0000_F0F0_1234, 64'h0F0F_FFFF_FF00_00FF);
        chk("and_run_in_ready", 64'(in_ready), 64'd0);
        chk("and_run_out", out, 64'd0);
        wait_done(lat);
        chk("and_latency", 64'(lat), 64'd4);
        chk("and_out", out, 64'h0F0F_0000_F000_0034);
        chk("and_zero", 64'(zero), 64'd0);
        chk("and_ones", 64'(ones), 64'd0);
        release_out();
        chk("and_back_idle", 64'(in_ready), 64'd1);
        chk("and_valid_drop", 64'(out_valid), 64'd0);

        // XOR of equal operands -> zero
        start(2'b10, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D);
        wait_done(lat);
        chk("xor_latency", 64'(lat), 64'd4);
        chk("xor_out", out, 64'd0);
        chk("xor_zero", 64'(zero), 64'd1);
        chk("xor_ones", 64'(ones), 64'd0);
        release_out();

        // OR of complements -> all ones
        start(2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
        wait_done(lat);
        chk("or_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("or_ones", 64'(ones), 64'd1);
        chk("or_zero", 64'(zero), 64'd0);
        release_out();

        // ANDN with a ten-cycle consumer stall and input noise in DONE
        start(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF);
        wait_done(lat);
        chk("andn_out", out, 64'hFFFF_FFFF_FFFF_FF00);
        snap = out;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            op = 2'(i);
            in1 = {$urandom, $urandom};
            in2 = {$urandom, $urandom};
            tick();
            if (out !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("andn_hold_stable", 64'(stable), 64'd1);
        chk("andn_hold_out", out, 64'hFFFF_FFFF_FFFF_FF00);
        release_out();
        chk("andn_release_in_ready", 64'(in_ready), 64'd1);
        chk("andn_release_out", out, 64'd0);

        // Operand changes, in_valid pulses and early out_ready during RUN are ignored
        start(2'b00, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            op = 2'(i + 1);
            in1 = {$urandom, $urandom};
            in2 = {$urandom, $urandom};
            in_valid = i[0];
            out_ready = 1'b1;
            tick();
            if (out_valid) extra++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("noise_early_valid", 64'(extra), 64'd0);
        tick();
        chk("noise_valid", 64'(out_valid), 64'd1);
        chk("noise_out", out, 64'h1234_0000_9ABC_0000);
        release_out();
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) extra++;
        end
        chk("noise_single_episode", 64'(extra), 64'd0);

        // Reset in the second RUN cycle abandons the request
        start(2'b01, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrun_in_ready", 64'(in_ready), 64'd1);
        chk("rstrun_out_valid", 64'(out_valid), 64'd0);
        chk("rstrun_out", out, 64'd0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) extra++;
        end
        chk("rstrun_no_valid", 64'(extra), 64'd0);

        // Reset beats a simultaneous accept
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_prio_in_ready", 64'(in_ready), 64'd1);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) extra++;
        end
        chk("rst_prio_no_valid", 64'(extra), 64'd0);

        // Small geometries: 32/32 (latency 1) and 24/8 (latency 3)
        for (int r = 0; r < 8; r++) begin
            s_op = 2'(r);
            if (r == 0) begin
                s_a = 32'hFFFF_FFFF; s_b = 32'hFFFF_FFFF;
            end else if (r == 6) begin
                s_a = 32'h00C3_5A5A; s_b = 32'h12C3_5A5A;
            end else begin
                s_a = $urandom; s_b = $urandom;
            end
            s_in_valid = 1'b1;
            tick();
            s_in_valid = 1'b0;
            s_a = $urandom;
            s_b = $urandom;
            s_op = 2'(r + 1);
            la = -1; lb = -1; oa = '0; ob = '0; obz = 1'b0; obo = 1'b0;
            for (int c = 1; c <= 5 + (r % 3); c++) begin
                tick();
                if (a_out_valid && la < 0) begin la = c; oa = a_out; end
                if (b_out_valid && lb < 0) begin lb = c; ob = b_out; obz = b_zero; obo = b_ones; end
            end
            chk("w32_latency", 64'(la), 64'd1);
            chk("w24_latency", 64'(lb), 64'd3);
            chk("w32_hold", 64'(a_out), 64'(oa));
            if (r == 0) begin
                e = ref_op(2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
            end else if (r == 6) begin
                e = ref_op(2'b10, 64'h00C3_5A5A, 64'h12C3_5A5A);
            end else begin
                e = 64'hx;
            end
            if (r == 0 || r == 6) begin
                chk("w32_out", 64'(oa), e & 64'hFFFF_FFFF);
                chk("w24_out", 64'(ob), e & 64'hFF_FFFF);
                chk("w24_zero", 64'(obz), (r == 6) ? 64'd1 : 64'd0);
                chk("w24_ones", 64'(obo), (r == 0) ? 64'd1 : 64'd0);
            end
            s_out_ready = 1'b1;
            tick();
            s_out_ready = 1'b0;
            chk("w32_idle", 64'(a_in_ready), 64'd1);
            chk("w24_idle", 64'(b_in_ready), 64'd1);
        end

        // Random operands checked against the reference model
        for (int r = 0; r < 12; r++) begin
            logic [31:0] ra, rb;
            logic [1:0]  ro;
            ra = $urandom; rb = $urandom; ro = 2'(r);
            s_a = ra; s_b = rb; s_op = ro;
            s_in_valid = 1'b1;
            tick();
            s_in_valid = 1'b0;
            s_a = ~ra;
            la = 0;
            while (!(a_out_valid && b_out_valid) && la < 10) begin
                tick();
                la++;
            end
            e = ref_op(ro, 64'(ra), 64'(rb));
            chk("rand_w32_out", 64'(a_out), e & 64'hFFFF_FFFF);
            chk("rand_w24_out", 64'(b_out), e & 64'hFF_FFFF);
            s_out_ready = 1'b1;
            tick();
            s_out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
